// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states
// and datapath mux selects, plus the one-hot opcode class bundle.
package rv_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WD_W    = 8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [STATE_W-1:0] ST_FETCH   = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXECUTE = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEM     = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB      = 3'd4;
  localparam logic [STATE_W-1:0] ST_HALT    = 3'd7;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic op;
    logic op_imm;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } opclass_t;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Shared instruction/data memory request/ack bundle between controller and memory.
interface rv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/rv_opclass.sv
// Opcode/funct3 to one-hot instruction class; illegal_c when no legal class matches.
module rv_opclass
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output opclass_t   cls_c,
  output logic       illegal_c
);

  logic mem_f3_bad_c;

  // Widths 3 and 6/7 have no RV32I load/store encoding.
  assign mem_f3_bad_c = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);

  always_comb begin
    cls_c     = '0;
    illegal_c = 1'b0;
    case (opcode)
      OPC_OP:     cls_c.op     = 1'b1;
      OPC_OP_IMM: cls_c.op_imm = 1'b1;
      OPC_LOAD:   if (mem_f3_bad_c) illegal_c = 1'b1; else cls_c.load = 1'b1;
      OPC_STORE:  if (mem_f3_bad_c) illegal_c = 1'b1; else cls_c.store = 1'b1;
      OPC_BRANCH: cls_c.branch = 1'b1;
      OPC_JAL:    cls_c.jal    = 1'b1;
      OPC_JALR:   cls_c.jalr   = 1'b1;
      OPC_LUI:    cls_c.lui    = 1'b1;
      OPC_AUIPC:  cls_c.auipc  = 1'b1;
      OPC_SYSTEM: illegal_c    = 1'b1;
      default:    illegal_c    = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (fetch/decode/execute/mem/wb).
// Optional retired-instruction counter enabled by RV_CTRL_INSTRET_EN.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  rv_multicycle_ctrl_if.master       mem,
  input  logic [6:0]                 opcode,
  input  logic [2:0]                 funct3,
  input  logic                       br_taken,
  output logic                       pc_we,
  output logic [1:0]                 pc_sel,
  output logic                       ir_we,
  output logic                       rf_we,
  output logic                       alu_a_sel,
  output logic                       alu_b_sel,
  output logic [2:0]                 imm_sel,
  output logic [1:0]                 wb_sel,
  output logic                       halt,
  output logic [STATE_W-1:0]         state_o,
  output logic [31:0]                instret
);

  localparam bit             WD_EN   = (MEM_WAIT_MAX != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_WAIT_MAX - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [WD_W-1:0]    wd_cnt;
  opclass_t           cls;
  logic               illegal_c;
  logic               req_c;
  logic               wd_hit_c;
  logic [2:0]         imm_c;
  logic               alu_a_c;
  logic               alu_b_c;

  rv_opclass u_opclass (
    .opcode    (opcode),
    .funct3    (funct3),
    .cls_c     (cls),
    .illegal_c (illegal_c)
  );

  assign req_c        = !rst && ((state == ST_FETCH) || (state == ST_MEM));
  assign mem.mem_req  = req_c;
  // The counter reaches the limit on this edge unless the ack arrives now.
  assign wd_hit_c     = WD_EN && req_c && !mem.mem_ready && (wd_cnt == WD_LAST);

  // Immediate format and ALU operand selects per instruction class.
  always_comb begin
    imm_c = IMM_I;
    if (cls.store)                 imm_c = IMM_S;
    else if (cls.branch)           imm_c = IMM_SB;
    else if (cls.lui || cls.auipc) imm_c = IMM_U;
    else if (cls.jal)              imm_c = IMM_UJ;
    alu_a_c = cls.auipc || cls.jal;
    alu_b_c = !(cls.op || cls.branch);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                wd_cnt <= '0;
    else if (mem.mem_ready) wd_cnt <= '0;
    else if (req_c)         wd_cnt <= wd_cnt + WD_W'(1);
  end

  // Next state and datapath controls; everything stays 0 while rst is high.
  always_comb begin
    state_nxt        = state;
    pc_we            = 1'b0;
    pc_sel           = PC_PLUS4;
    ir_we            = 1'b0;
    rf_we            = 1'b0;
    alu_a_sel        = 1'b0;
    alu_b_sel        = 1'b0;
    imm_sel          = IMM_I;
    wb_sel           = WB_ALU;
    halt             = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          if (mem.mem_ready) begin
            ir_we     = 1'b1;
            state_nxt = ST_DECODE;
          end else if (wd_hit_c) begin
            state_nxt = ST_HALT;
          end
        end
        ST_DECODE: state_nxt = illegal_c ? ST_HALT : ST_EXECUTE;
        ST_EXECUTE: begin
          imm_sel   = imm_c;
          alu_a_sel = alu_a_c;
          alu_b_sel = alu_b_c;
          if (cls.branch) begin
            pc_we     = 1'b1;
            pc_sel    = br_taken ? PC_REL : PC_PLUS4;
            state_nxt = ST_FETCH;
          end else if (cls.jal || cls.jalr) begin
            pc_we     = 1'b1;
            pc_sel    = cls.jal ? PC_REL : PC_JALR;
            rf_we     = 1'b1;
            wb_sel    = WB_PC4;
            state_nxt = ST_FETCH;
          end else if (cls.load || cls.store) begin
            state_nxt = ST_MEM;
          end else if (cls.op || cls.op_imm || cls.lui || cls.auipc) begin
            state_nxt = ST_WB;
          end else begin
            state_nxt = ST_HALT;
          end
        end
        ST_MEM: begin
          imm_sel          = imm_c;
          alu_a_sel        = alu_a_c;
          alu_b_sel        = alu_b_c;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = cls.store;
          if (mem.mem_ready) begin
            if (cls.store) begin
              pc_we     = 1'b1;
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_WB;
            end
          end else if (wd_hit_c) begin
            state_nxt = ST_HALT;
          end
        end
        ST_WB: begin
          imm_sel   = imm_c;
          alu_a_sel = alu_a_c;
          alu_b_sel = alu_b_c;
          rf_we     = 1'b1;
          pc_we     = 1'b1;
          wb_sel    = cls.load ? WB_MEM : WB_ALU;
          state_nxt = ST_FETCH;
        end
        ST_HALT: halt = 1'b1;
        default: state_nxt = ST_HALT;
      endcase
    end
  end

  assign state_o = rst ? '0 : state;

`ifdef RV_CTRL_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)        instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + 32'd1;
  end

  assign instret = rst ? '0 : instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: a phase-level instruction model pushes
// expected per-cycle controls, a negedge monitor pops and compares them.
module tb_rv_multicycle_ctrl;

  localparam int WD_MAX = 4;

  typedef struct packed {
    logic [2:0]  state;
    logic        halt;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        ir_we;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        rf_we;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [2:0]  imm_sel;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
  } obs_t;

  typedef enum int {C_OP, C_OPIMM, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_e;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        br_taken;
  logic        pc_we, ir_we, rf_we, alu_a_sel, alu_b_sel, halt;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state_o;
  logic [31:0] instret;

  rv_multicycle_ctrl_if mem_if ();

  rv_multicycle_ctrl #(.MEM_WAIT_MAX(WD_MAX)) dut (
    .clk (clk), .rst (rst), .mem (mem_if),
    .opcode (opcode), .funct3 (funct3), .br_taken (br_taken),
    .pc_we (pc_we), .pc_sel (pc_sel), .ir_we (ir_we), .rf_we (rf_we),
    .alu_a_sel (alu_a_sel), .alu_b_sel (alu_b_sel), .imm_sel (imm_sel),
    .wb_sel (wb_sel), .halt (halt), .state_o (state_o), .instret (instret)
  );

  always #5 clk = ~clk;

  obs_t  q_exp [$];
  string q_tag [$];
  int    total = 0;
  int    bad   = 0;
  int    exp_instret = 0;
  bit    halted = 0;
  bit    done = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic cls_e classify(input logic [31:0] w);
    logic [2:0] f = w[14:12];
    bit badf = (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
    case (w[6:0])
      7'b0110011: return C_OP;
      7'b0010011: return C_OPIMM;
      7'b0000011: return badf ? C_ILL : C_LOAD;
      7'b0100011: return badf ? C_ILL : C_STORE;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  // Immediate format and ALU operand choice implied by each instruction class.
  function automatic obs_t with_sel(input obs_t o, input cls_e c);
    o.imm_sel   = (c == C_STORE) ? 3'd1 : (c == C_BR) ? 3'd2 :
                  (c == C_LUI || c == C_AUIPC) ? 3'd3 : (c == C_JAL) ? 3'd4 : 3'd0;
    o.alu_a_sel = (c == C_AUIPC) || (c == C_JAL);
    o.alu_b_sel = !((c == C_OP) || (c == C_BR));
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  tbl [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    logic [31:0] w = $urandom();
    int          k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = tbl[k];
    return w;
  endfunction

  task automatic cyc(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                     input logic br, input logic rdy, input obs_t e, input string tag);
    @(posedge clk);
    #1;
    rst = r; opcode = opc; funct3 = f3; br_taken = br; mem_if.mem_ready = rdy;
`ifdef RV_CTRL_INSTRET_EN
    e.instret = 32'(exp_instret);
`else
    e.instret = '0;
`endif
    q_exp.push_back(e);
    q_tag.push_back(tag);
    if (e.pc_we) exp_instret++;
  endtask

  task automatic do_reset(input int n);
    exp_instret = 0;
    for (int i = 0; i < n; i++)
      cyc(1'b1, 7'($urandom()), 3'($urandom()), rb(), rb(), '0, "reset");
    halted = 0;
  endtask

  task automatic halt_cycles(input int n, input string tag);
    obs_t e = mk(3'd7);
    e.halt = 1'b1;
    for (int i = 0; i < n; i++)
      cyc(1'b0, 7'($urandom()), 3'($urandom()), rb(), rb(), e, tag);
    halted = 1;
  endtask

  // One memory request: dly wait cycles then ack, or watchdog HALT, or reset at abort_at.
  task automatic mem_phase(input bit fetch, input int dly, input logic [6:0] opc,
                           input logic [2:0] f3, input cls_e c, input int abort_at, output bit ok);
    obs_t e;
    int   nwait;
    e = fetch ? mk(3'd0) : with_sel(mk(3'd3), c);
    e.mem_req = 1'b1;
    if (!fetch) begin
      e.mem_addr_sel = 1'b1;
      e.mem_we       = (c == C_STORE);
    end
    ok = 0;
    nwait = (dly < WD_MAX) ? dly : WD_MAX;
    for (int i = 0; i < nwait; i++) begin
      if (i == abort_at) begin
        do_reset(1);
        return;
      end
      cyc(1'b0, fetch ? 7'($urandom()) : opc, fetch ? 3'($urandom()) : f3, rb(), 1'b0, e,
          fetch ? "fetch_wait" : "mem_wait");
    end
    if (dly >= WD_MAX) begin
      halt_cycles(3, "wd_halt");
      return;
    end
    if (fetch) e.ir_we = 1'b1;
    else if (c == C_STORE) e.pc_we = 1'b1;
    cyc(1'b0, fetch ? 7'($urandom()) : opc, fetch ? 3'($urandom()) : f3, rb(), 1'b1, e,
        fetch ? "fetch_ack" : "mem_ack");
    ok = 1;
  endtask

  task automatic wb(input cls_e c, input logic [6:0] opc, input logic [2:0] f3);
    obs_t e = with_sel(mk(3'd4), c);
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = (c == C_LOAD) ? 2'd1 : 2'd0;
    cyc(1'b0, opc, f3, rb(), rb(), e, "wb");
  endtask

  task automatic run_instr(input logic [31:0] w, input int fd, input int md,
                           input logic br, input int abort_at);
    cls_e       c   = classify(w);
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    obs_t       e;
    bit         ok;
    mem_phase(1'b1, fd, opc, f3, c, -1, ok);
    if (!ok) return;
    cyc(1'b0, opc, f3, rb(), rb(), mk(3'd1), "decode");
    if (c == C_ILL) begin
      halt_cycles(3, "halt");
      return;
    end
    e = with_sel(mk(3'd2), c);
    case (c)
      C_BR: begin
        e.pc_we  = 1'b1;
        e.pc_sel = br ? 2'd1 : 2'd0;
        cyc(1'b0, opc, f3, br, rb(), e, "exec_branch");
      end
      C_JAL, C_JALR: begin
        e.pc_we  = 1'b1;
        e.rf_we  = 1'b1;
        e.wb_sel = 2'd2;
        e.pc_sel = (c == C_JAL) ? 2'd1 : 2'd2;
        cyc(1'b0, opc, f3, rb(), rb(), e, "exec_jump");
      end
      C_LOAD, C_STORE: begin
        cyc(1'b0, opc, f3, rb(), rb(), e, "exec_addr");
        mem_phase(1'b0, md, opc, f3, c, abort_at, ok);
        if (ok && c == C_LOAD) wb(c, opc, f3);
      end
      default: begin
        cyc(1'b0, opc, f3, rb(), rb(), e, "exec_alu");
        wb(c, opc, f3);
      end
    endcase
  endtask

  obs_t  m_exp, m_act;
  string m_tag;

  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      m_exp = q_exp.pop_front();
      m_tag = q_tag.pop_front();
      m_act = '0;
      m_act.state        = state_o;
      m_act.halt         = halt;
      m_act.pc_we        = pc_we;
      m_act.pc_sel       = pc_sel;
      m_act.ir_we        = ir_we;
      m_act.mem_req      = mem_if.mem_req;
      m_act.mem_we       = mem_if.mem_we;
      m_act.mem_addr_sel = mem_if.mem_addr_sel;
      m_act.rf_we        = rf_we;
      m_act.alu_a_sel    = alu_a_sel;
      m_act.alu_b_sel    = alu_b_sel;
      m_act.imm_sel      = imm_sel;
      m_act.wb_sel       = wb_sel;
      m_act.instret      = instret;
      total++;
      if (m_tag == "reset") begin
        if (m_act !== obs_t'(0)) begin
          bad++;
          $display("FAIL reset at %0t: outputs not all zero during reset: got=%h", $time, m_act);
        end
      end else if (m_tag == "wd_halt") begin
        if ((state_o !== 3'd7) || (halt !== 1'b1) || (mem_if.mem_req !== 1'b0) || (m_act !== m_exp)) begin
          bad++;
          $display("FAIL wd_halt at %0t: expired wait did not halt: got=%h want=%h", $time, m_act, m_exp);
        end
      end else if (m_act !== m_exp) begin
        bad++;
        $display("FAIL %s at %0t: got=%h want=%h (state,halt,pc_we,pc_sel,ir_we,req,we,asel,rf_we,a,b,imm,wb,instret)",
                 m_tag, $time, m_act, m_exp);
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; br_taken = 1'b0; mem_if.mem_ready = 1'b0;
    do_reset(2);
    run_instr(32'h002081B3, 0, 0, 1'b0, -1);   // ADD
    run_instr(32'h0040A183, 3, 3, 1'b0, -1);   // LW, ack 3 cycles late twice
    run_instr(32'h00208463, 0, 0, 1'b1, -1);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0, -1);   // BEQ not taken
    run_instr(32'h000080E7, 0, 0, 1'b0, -1);   // JALR
    run_instr(32'h00000000, 1, 0, 1'b0, -1);   // illegal opcode
    do_reset(1);
    run_instr(32'h00000073, 0, 0, 1'b0, -1);   // ECALL
    do_reset(2);
    run_instr(32'h0020A023, 0, 6, 1'b0, 2);    // SW, reset during MEM wait
    run_instr(32'h002081B3, 0, 0, 1'b0, -1);
    run_instr(32'h0040A183, 0, 5, 1'b0, -1);   // watchdog in MEM
    do_reset(1);
    run_instr(32'h002081B3, 4, 0, 1'b0, -1);   // watchdog in FETCH
    do_reset(1);
    for (int n = 0; n < 300; n++) begin
      if (halted) do_reset(int'($urandom_range(1, 2)));
      run_instr(rand_instr(), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), rb(),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
    end
    done = 1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
